// File: rtl/fpu_arbiter_if.sv
// Requester, response and shared-FPU signals of the two-port FPU arbiter.
// The arbiter takes the slave view, requesters the master view, the FPU the unit view.
interface fpu_arbiter_if;
    logic        req0_valid;
    logic        req0_ready;
    logic [31:0] req0_a;
    logic [31:0] req0_b;
    logic [1:0]  req0_op;
    logic        req1_valid;
    logic        req1_ready;
    logic [31:0] req1_a;
    logic [31:0] req1_b;
    logic [1:0]  req1_op;

    logic        resp0_valid;
    logic        resp0_ready;
    logic [31:0] resp0_data;
    logic        resp1_valid;
    logic        resp1_ready;
    logic [31:0] resp1_data;

    logic [31:0] fpu_a;
    logic [31:0] fpu_b;
    logic [1:0]  fpu_opcode;
    logic [31:0] fpu_o;
    logic        busy;

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_op,
        input  req1_valid, req1_a, req1_b, req1_op,
        output req0_ready, req1_ready,
        output resp0_valid, resp0_data, resp1_valid, resp1_data,
        input  resp0_ready, resp1_ready,
        output fpu_a, fpu_b, fpu_opcode, busy,
        input  fpu_o
    );

    modport master (
        output req0_valid, req0_a, req0_b, req0_op,
        output req1_valid, req1_a, req1_b, req1_op,
        input  req0_ready, req1_ready,
        input  resp0_valid, resp0_data, resp1_valid, resp1_data,
        output resp0_ready, resp1_ready,
        input  busy
    );

    modport unit (
        input  fpu_a, fpu_b, fpu_opcode,
        output fpu_o
    );
endinterface

// File: rtl/fpu_arbiter.sv
// Round-robin arbiter giving two requesters access to one fixed-latency FPU.
// One operation is in flight at a time; the result is held until its owner consumes it.
module fpu_arbiter #(
    parameter int FPU_LAT = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    fpu_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    localparam logic [3:0] LAT_LOAD = 4'(FPU_LAT);

    state_t      state_q;
    logic [3:0]  cnt_q;
    logic        ptr_q;
    logic        owner_q;
    logic [31:0] fpu_a_q;
    logic [31:0] fpu_b_q;
    logic [1:0]  op_q;
    logic [31:0] result_q;
    logic        resp0_valid_q;
    logic        resp1_valid_q;
    logic        busy_q;

    logic        gnt0;
    logic        gnt1;
    logic        owner_ready;

    // Pointer only breaks ties; a lone requester always wins.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (state_q == IDLE) begin
            if (bus.req0_valid && bus.req1_valid) begin
                gnt0 = ~ptr_q;
                gnt1 = ptr_q;
            end else begin
                gnt0 = bus.req0_valid;
                gnt1 = bus.req1_valid;
            end
        end
    end

    assign owner_ready = owner_q ? bus.resp1_ready : bus.resp0_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            cnt_q         <= 4'd0;
            ptr_q         <= 1'b0;
            owner_q       <= 1'b0;
            fpu_a_q       <= 32'd0;
            fpu_b_q       <= 32'd0;
            op_q          <= 2'b00;
            result_q      <= 32'd0;
            resp0_valid_q <= 1'b0;
            resp1_valid_q <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (gnt0 || gnt1) begin
                        fpu_a_q <= gnt1 ? bus.req1_a  : bus.req0_a;
                        fpu_b_q <= gnt1 ? bus.req1_b  : bus.req0_b;
                        op_q    <= gnt1 ? bus.req1_op : bus.req0_op;
                        owner_q <= gnt1;
                        ptr_q   <= ~gnt1;
                        cnt_q   <= LAT_LOAD;
                        busy_q  <= 1'b1;
                        state_q <= WAIT;
                    end
                end
                WAIT: begin
                    cnt_q <= cnt_q - 4'd1;
                    // Counter hits zero on this edge: the FPU output is valid now.
                    if (cnt_q == 4'd1) begin
                        result_q      <= bus.fpu_o;
                        resp0_valid_q <= ~owner_q;
                        resp1_valid_q <= owner_q;
                        state_q       <= RESP;
                    end
                end
                RESP: begin
                    if (owner_ready) begin
                        resp0_valid_q <= 1'b0;
                        resp1_valid_q <= 1'b0;
                        busy_q        <= 1'b0;
                        state_q       <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.req0_ready  = gnt0;
    assign bus.req1_ready  = gnt1;
    assign bus.resp0_valid = resp0_valid_q;
    assign bus.resp1_valid = resp1_valid_q;
    assign bus.resp0_data  = result_q;
    assign bus.resp1_data  = result_q;
    assign bus.fpu_a       = fpu_a_q;
    assign bus.fpu_b       = fpu_b_q;
    assign bus.fpu_opcode  = op_q;
    assign bus.busy        = busy_q;
endmodule

// File: tb/tb_fpu_arbiter.sv
// Bench for fpu_arbiter: a behavioural FPU with pipelined latency, a scoreboard of
// expected results, and two extra instances at the latency extremes.
`timescale 1ns/1ps
module tb_fpu_arbiter;
    localparam int LAT = 2;
    localparam logic [31:0] A0 = 32'h12002B28;
    localparam logic [31:0] B0 = 32'h1183E094;
    localparam logic [31:0] A1 = 32'h6EE4B94C;
    localparam logic [31:0] B1 = 32'h46BA2510;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];
    int          own_q[$];
    logic [31:0] last_a;
    logic [31:0] last_b;
    logic [1:0]  last_op;

    // Single-precision helpers for the reference FPU (normal numbers only).
    function automatic real sp_to_real(input logic [31:0] s);
        logic [63:0] d;
        if (s[30:23] == 8'd0) return 0.0;
        d = {s[31], {3'd0, s[30:23]} + 11'd896, s[22:0], 29'd0};
        return $bitstoreal(d);
    endfunction

    function automatic logic [31:0] real_to_sp(input real r);
        logic [63:0] d;
        logic [23:0] mr;
        logic [10:0] e;
        logic        rnd;
        d = $realtobits(r);
        if (d[62:52] == 11'd0) return 32'd0;
        rnd = d[28] && ((|d[27:0]) || d[29]);
        mr  = {1'b0, d[51:29]} + {23'd0, rnd};
        e   = d[62:52] - 11'd896 + {10'd0, mr[23]};
        return {d[63], e[7:0], mr[22:0]};
    endfunction

    function automatic logic [31:0] fpu_func(input logic [31:0] a, input logic [31:0] b,
                                             input logic [1:0] op);
        if (op == 2'b10) return real_to_sp(sp_to_real(a) / sp_to_real(b));
        return a ^ {b[15:0], b[31:16]} ^ {30'd0, op};
    endfunction

    // Main instance, FPU_LAT = 2
    fpu_arbiter_if bus ();
    fpu_arbiter #(.FPU_LAT(LAT)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));
    logic [31:0] pm;
    always_ff @(posedge clk) pm <= fpu_func(bus.fpu_a, bus.fpu_b, bus.fpu_opcode);
    assign bus.fpu_o = pm;

    // Latency-extreme instances share one requester-0 stimulus
    logic        v_valid = 1'b0;
    logic        v_rready = 1'b0;
    logic [31:0] v_a = 32'd0;
    logic [31:0] v_b = 32'd0;
    logic [1:0]  v_op = 2'b00;

    fpu_arbiter_if l1 ();
    fpu_arbiter #(.FPU_LAT(1)) dut_l1 (.clk(clk), .rst_n(rst_n), .bus(l1.slave));
    assign l1.req0_valid = v_valid;
    assign l1.req0_a = v_a;
    assign l1.req0_b = v_b;
    assign l1.req0_op = v_op;
    assign l1.req1_valid = 1'b0;
    assign l1.req1_a = 32'd0;
    assign l1.req1_b = 32'd0;
    assign l1.req1_op = 2'b00;
    assign l1.resp0_ready = v_rready;
    assign l1.resp1_ready = 1'b0;
    assign l1.fpu_o = fpu_func(l1.fpu_a, l1.fpu_b, l1.fpu_opcode);

    fpu_arbiter_if l15 ();
    fpu_arbiter #(.FPU_LAT(15)) dut_l15 (.clk(clk), .rst_n(rst_n), .bus(l15.slave));
    logic [31:0] p15 [0:13];
    always_ff @(posedge clk) begin
        p15[0] <= fpu_func(l15.fpu_a, l15.fpu_b, l15.fpu_opcode);
        for (int i = 1; i < 14; i++) p15[i] <= p15[i-1];
    end
    assign l15.req0_valid = v_valid;
    assign l15.req0_a = v_a;
    assign l15.req0_b = v_b;
    assign l15.req0_op = v_op;
    assign l15.req1_valid = 1'b0;
    assign l15.req1_a = 32'd0;
    assign l15.req1_b = 32'd0;
    assign l15.req1_op = 2'b00;
    assign l15.resp0_ready = v_rready;
    assign l15.resp1_ready = 1'b0;
    assign l15.fpu_o = p15[13];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic init();
        bus.req0_valid = 1'b0; bus.req0_a = 32'd0; bus.req0_b = 32'd0; bus.req0_op = 2'b00;
        bus.req1_valid = 1'b0; bus.req1_a = 32'd0; bus.req1_b = 32'd0; bus.req1_op = 2'b00;
        bus.resp0_ready = 1'b0; bus.resp1_ready = 1'b0;
    endtask

    // Present an operation on requester n, wait for its grant, record the expectation.
    task automatic send(input int n, input logic [31:0] a, input logic [31:0] b, input logic [1:0] op);
        int k = 0;
        if (n == 0) begin
            bus.req0_a = a; bus.req0_b = b; bus.req0_op = op; bus.req0_valid = 1'b1;
        end else begin
            bus.req1_a = a; bus.req1_b = b; bus.req1_op = op; bus.req1_valid = 1'b1;
        end
        #1;
        while (!(n == 0 ? bus.req0_ready : bus.req1_ready) && k < 40) begin
            tick(); #1; k++;
        end
        checks++;
        if ((n == 0 ? bus.req0_ready : bus.req1_ready) !== 1'b1 ||
            (n == 0 ? bus.req1_ready : bus.req0_ready) !== 1'b0) begin
            errors++;
            $display("FAIL send%0d_grant: rdy0=%b rdy1=%b after %0d cycles, required only rdy%0d high",
                     n, bus.req0_ready, bus.req1_ready, k, n);
        end else begin
            exp_q.push_back(fpu_func(a, b, op));
            own_q.push_back(n);
            last_a = a; last_b = b; last_op = op;
        end
        tick();
        if (n == 0) bus.req0_valid = 1'b0; else bus.req1_valid = 1'b0;
    endtask

    // Called just after the accept edge: wait for respN_valid, compare against the
    // scoreboard, optionally stall the consumer, then consume.
    task automatic recv(input int n, input int lat, input int stall, input bit chk_hi, input logic [19:0] hi);
        int k = 0;
        int own;
        logic [31:0] exp;
        logic [31:0] held;
        logic [31:0] d;
        while (!(n == 0 ? bus.resp0_valid : bus.resp1_valid) && k < 40) begin
            checks++;
            if (bus.req0_ready || bus.req1_ready || !bus.busy || bus.resp0_valid || bus.resp1_valid ||
                bus.fpu_a !== last_a || bus.fpu_b !== last_b || bus.fpu_opcode !== last_op) begin
                errors++;
                $display("FAIL wait%0d_state: rdy=%b%b busy=%b vld=%b%b fpu=%h/%h/%b, required rdy=00 busy=1 vld=00 fpu=%h/%h/%b",
                         n, bus.req0_ready, bus.req1_ready, bus.busy, bus.resp0_valid, bus.resp1_valid,
                         bus.fpu_a, bus.fpu_b, bus.fpu_opcode, last_a, last_b, last_op);
            end
            tick(); k++;
        end
        checks++;
        if (k >= 40) begin
            errors++;
            $display("FAIL resp%0d_timeout: valid=0 after %0d cycles, required 1", n, k);
            return;
        end
        checks++;
        if (lat >= 0 && k != lat) begin
            errors++;
            $display("FAIL resp%0d_latency: %0d edges, required %0d", n, k, lat);
        end
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL resp%0d_scoreboard: response with no expectation queued, required none", n);
            return;
        end
        exp = exp_q.pop_front();
        own = own_q.pop_front();
        checks++;
        if (own != n || bus.resp0_data !== exp || bus.resp1_data !== exp ||
            (n == 0 ? bus.resp1_valid : bus.resp0_valid)) begin
            errors++;
            $display("FAIL resp%0d_data: owner=%0d d0=%h d1=%h other_vld=%b, required owner=%0d data=%h other_vld=0",
                     n, own, bus.resp0_data, bus.resp1_data, (n == 0 ? bus.resp1_valid : bus.resp0_valid), n, exp);
        end
        d = (n == 0) ? bus.resp0_data : bus.resp1_data;
        if (chk_hi) begin
            checks++;
            if (d[31:12] !== hi) begin
                errors++;
                $display("FAIL resp%0d_hi20: got %h, required %h", n, d[31:12], hi);
            end
        end
        held = d;
        for (int s = 0; s < stall; s++) begin
            d = (n == 0) ? bus.resp0_data : bus.resp1_data;
            checks++;
            if (!(n == 0 ? bus.resp0_valid : bus.resp1_valid) || d !== held || !bus.busy ||
                bus.req0_ready || bus.req1_ready) begin
                errors++;
                $display("FAIL resp%0d_stall: cycle %0d vld=%b data=%h busy=%b rdy=%b%b, required vld=1 data=%h busy=1 rdy=00",
                         n, s, (n == 0 ? bus.resp0_valid : bus.resp1_valid), d, bus.busy,
                         bus.req0_ready, bus.req1_ready, held);
            end
            tick();
        end
        if (n == 0) bus.resp0_ready = 1'b1; else bus.resp1_ready = 1'b1;
        #1;
        checks++;
        if (bus.req0_ready || bus.req1_ready) begin
            errors++;
            $display("FAIL resp%0d_exit_grant: rdy=%b%b on RESP exit edge, required 00", n, bus.req0_ready, bus.req1_ready);
        end
        tick();
        if (n == 0) bus.resp0_ready = 1'b0; else bus.resp1_ready = 1'b0;
        checks++;
        if (bus.busy || bus.resp0_valid || bus.resp1_valid) begin
            errors++;
            $display("FAIL resp%0d_release: busy=%b vld=%b%b, required 0 00", n, bus.busy, bus.resp0_valid, bus.resp1_valid);
        end
    endtask

    task automatic test_reset();
        tick();
        checks++;
        if ({bus.busy, bus.resp0_valid, bus.resp1_valid, bus.req0_ready, bus.req1_ready} !== 5'b0 ||
            bus.fpu_a !== 32'd0 || bus.fpu_b !== 32'd0 || bus.fpu_opcode !== 2'b00 || bus.resp0_data !== 32'd0) begin
            errors++;
            $display("FAIL reset_vals: busy=%b vld=%b%b rdy=%b%b fpu=%h/%h/%b data=%h, required all zero",
                     bus.busy, bus.resp0_valid, bus.resp1_valid, bus.req0_ready, bus.req1_ready,
                     bus.fpu_a, bus.fpu_b, bus.fpu_opcode, bus.resp0_data);
        end
        tick();
        rst_n = 1'b1;
        tick();
        checks++;
        if (bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: busy=%b, required 0", bus.busy);
        end
    endtask

    task automatic test_single();
        send(0, A0, B0, 2'b10);
        recv(0, LAT, 0, 1'b1, 20'h3FF8C);
    endtask

    task automatic test_stall();
        send(0, 32'h40490FDB, 32'h3F000000, 2'b01);
        bus.req1_a = A1; bus.req1_b = B1; bus.req1_op = 2'b10;
        bus.req1_valid = 1'b1;
        bus.resp1_ready = 1'b1;
        recv(0, LAT, 5, 1'b0, 20'h0);
        bus.resp1_ready = 1'b0;
        send(1, A1, B1, 2'b10);
        recv(1, LAT, 0, 1'b1, 20'h679D4);
    endtask

    task automatic test_drop();
        send(0, 32'h3F800000, 32'h12345678, 2'b00);
        bus.req1_a = 32'hDEADBEEF; bus.req1_b = 32'h0BADF00D; bus.req1_op = 2'b11;
        bus.req1_valid = 1'b1;
        tick();
        bus.req1_valid = 1'b0;
        recv(0, LAT - 1, 0, 1'b0, 20'h0);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (bus.busy || bus.req1_ready) begin
                errors++;
                $display("FAIL drop_ghost: busy=%b rdy1=%b, required 0 0", bus.busy, bus.req1_ready);
            end
            tick();
        end
    endtask

    task automatic test_back_to_back();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        bus.req0_a = A0; bus.req0_b = B0; bus.req0_op = 2'b10;
        bus.req1_a = A1; bus.req1_b = B1; bus.req1_op = 2'b10;
        bus.req0_valid = 1'b1;
        bus.req1_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            int w;
            w = i % 2;
            #1;
            checks++;
            if (bus.req0_ready !== (w == 0) || bus.req1_ready !== (w == 1)) begin
                errors++;
                $display("FAIL b2b_order: op %0d rdy=%b%b, required grant to %0d", i, bus.req0_ready, bus.req1_ready, w);
            end
            exp_q.push_back(w == 1 ? fpu_func(A1, B1, 2'b10) : fpu_func(A0, B0, 2'b10));
            own_q.push_back(w);
            last_a = (w == 1) ? A1 : A0;
            last_b = (w == 1) ? B1 : B0;
            last_op = 2'b10;
            tick();
            recv(w, LAT, 0, 1'b1, (w == 1) ? 20'h679D4 : 20'h3FF8C);
        end
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
    endtask

    task automatic test_lone();
        send(1, 32'h41200000, 32'h40A00000, 2'b10);
        recv(1, LAT, 0, 1'b0, 20'h0);
        bus.req0_a = 32'h11111111; bus.req0_b = 32'h22222222; bus.req0_op = 2'b01;
        bus.req1_a = 32'h33333333; bus.req1_b = 32'h44444444; bus.req1_op = 2'b11;
        bus.req0_valid = 1'b1;
        bus.req1_valid = 1'b1;
        #1;
        checks++;
        if (bus.req0_ready !== 1'b1 || bus.req1_ready !== 1'b0) begin
            errors++;
            $display("FAIL lone_pointer: rdy=%b%b, required grant to 0", bus.req0_ready, bus.req1_ready);
        end
        exp_q.push_back(fpu_func(32'h11111111, 32'h22222222, 2'b01));
        own_q.push_back(0);
        last_a = 32'h11111111; last_b = 32'h22222222; last_op = 2'b01;
        tick();
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        recv(0, LAT, 0, 1'b0, 20'h0);
    endtask

    task automatic test_reset_mid();
        send(0, 32'hC0490FDB, 32'h3F800000, 2'b01);
        tick();
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.busy, bus.resp0_valid, bus.resp1_valid} !== 3'b0 || bus.fpu_a !== 32'd0 ||
            bus.fpu_b !== 32'd0 || bus.fpu_opcode !== 2'b00 || bus.resp0_data !== 32'd0 || bus.resp1_data !== 32'd0) begin
            errors++;
            $display("FAIL midreset_vals: busy=%b vld=%b%b fpu=%h/%h/%b data=%h/%h, required all zero without an edge",
                     bus.busy, bus.resp0_valid, bus.resp1_valid, bus.fpu_a, bus.fpu_b, bus.fpu_opcode,
                     bus.resp0_data, bus.resp1_data);
        end
        exp_q.delete();
        own_q.delete();
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            checks++;
            if (bus.resp0_valid || bus.resp1_valid || bus.busy) begin
                errors++;
                $display("FAIL midreset_ghost: cycle %0d vld=%b%b busy=%b, required 00 0",
                         i, bus.resp0_valid, bus.resp1_valid, bus.busy);
            end
        end
    endtask

    task automatic test_lat_variants();
        int c1 = -1;
        int c15 = -1;
        int bad = 0;
        logic [31:0] e;
        e = fpu_func(A1, B1, 2'b10);
        v_a = A1; v_b = B1; v_op = 2'b10; v_valid = 1'b1;
        #1;
        checks++;
        if (l1.req0_ready !== 1'b1 || l15.req0_ready !== 1'b1) begin
            errors++;
            $display("FAIL lat_grant: rdy l1=%b l15=%b, required 1 1", l1.req0_ready, l15.req0_ready);
        end
        tick();
        v_valid = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (c1 < 0 && l1.resp0_valid) c1 = k;
            if (c15 < 0 && l15.resp0_valid) c15 = k;
            if (c1 < 0 && (l1.fpu_a !== A1 || l1.fpu_b !== B1 || l1.fpu_opcode !== 2'b10)) bad++;
            if (c15 < 0 && (l15.fpu_a !== A1 || l15.fpu_b !== B1 || l15.fpu_opcode !== 2'b10)) bad++;
            tick();
        end
        checks++;
        if (c1 != 1) begin
            errors++;
            $display("FAIL lat1_latency: %0d edges, required 1", c1);
        end
        checks++;
        if (c15 != 15) begin
            errors++;
            $display("FAIL lat15_latency: %0d edges, required 15", c15);
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL lat_operands: %0d cycles with changed fpu inputs, required 0", bad);
        end
        checks++;
        if (l1.resp0_data !== e || l15.resp0_data !== e) begin
            errors++;
            $display("FAIL lat_data: l1=%h l15=%h, required %h", l1.resp0_data, l15.resp0_data, e);
        end
        v_rready = 1'b1;
        tick();
        v_rready = 1'b0;
        checks++;
        if (l1.busy || l15.busy || l1.resp0_valid || l15.resp0_valid) begin
            errors++;
            $display("FAIL lat_release: busy=%b%b vld=%b%b, required 00 00", l1.busy, l15.busy, l1.resp0_valid, l15.resp0_valid);
        end
    endtask

    initial begin
        init();
        test_reset();
        test_single();
        test_stall();
        test_drop();
        test_back_to_back();
        test_lone();
        test_reset_mid();
        test_lat_variants();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit, required completion");
        $fatal(1);
    end
endmodule
